// File: rtl/vec_ctrl_pkg.sv
// Shared types for the vector sequencing controller: opcode/funct3/mop
// encodings, FSM state encoding and the latched control word.
package vec_ctrl_pkg;

  typedef enum logic [6:0] {
    V_ARITH = 7'b1010111,
    V_LOAD  = 7'b0000111,
    V_STORE = 7'b0100111
  } v_opcode_e;

  typedef enum logic [2:0] {
    F3_CONF = 3'b111
  } v_func3_e;

  // Memory addressing modes, instruction bits [27:26]
  localparam logic [1:0] MOP_UNIT      = 2'b00;
  localparam logic [1:0] MOP_IDX_UNORD = 2'b01;
  localparam logic [1:0] MOP_STRIDED   = 2'b10;
  localparam logic [1:0] MOP_IDX_ORD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONF  = 2'd1,
    MEM   = 2'd2,
    DRAIN = 2'd3
  } ctrl_state_e;

  // Every select driven toward vec_decode / vec_registerfile / vec_lsu
  typedef struct packed {
    logic       vl_sel;
    logic       vtype_sel;
    logic       rs1_sel;
    logic       rs1rd_de;
    logic       lumop_sel;
    logic       vec_reg_wr_en;
    logic [1:0] data_mux1_sel;
    logic       data_mux2_sel;
    logic       stride_sel;
    logic       index_str;
    logic       ld_inst;
    logic       st_inst;
  } vec_ctrl_word_t;

  // Element widths accepted for vector loads/stores
  function automatic logic mem_width_ok(input logic [2:0] width);
    return (width == 3'b000) || (width == 3'b101) ||
           (width == 3'b110) || (width == 3'b111);
  endfunction

endpackage

// File: rtl/vec_inst_decoder.sv
// Combinational decode of one vector instruction into the control word,
// plus the instruction class and a legality flag.
module vec_inst_decoder
  import vec_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] vec_inst,
  output vec_ctrl_word_t  ctrl,
  output logic            legal,
  output logic            is_conf,
  output logic            is_mem,
  output logic            ordered
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [1:0] mop;
  logic       rs1_rd_zero;
  logic       unused_fields;

  assign opcode      = vec_inst[6:0];
  assign funct3      = vec_inst[14:12];
  assign mop         = vec_inst[27:26];
  assign rs1_rd_zero = (vec_inst[19:15] == 5'd0) && (vec_inst[11:7] == 5'd0);
  // Fields that only matter further down the pipe
  assign unused_fields = ^{vec_inst[29:28], vec_inst[25:20]};

  // Opcode/funct3/mop decode
  // NOTE: every output gets a default first so no path through the case
  // leaves a value held, which would infer a latch.
  always_comb begin
    ctrl    = '0;
    legal   = 1'b0;
    is_conf = 1'b0;
    is_mem  = 1'b0;
    ordered = 1'b0;
    case (opcode)
      V_ARITH: begin
        if (funct3 == F3_CONF) begin
          legal   = 1'b1;
          is_conf = 1'b1;
          if (vec_inst[31] && vec_inst[30]) begin
            // vsetivli: AVL is an immediate
            ctrl.vl_sel    = 1'b1;
            ctrl.vtype_sel = 1'b1;
            ctrl.rs1rd_de  = 1'b1;
            ctrl.rs1_sel   = 1'b0;
          end else begin
            // vsetvli (bit31=0) takes vtype from the immediate; vsetvl from rs2
            ctrl.vl_sel    = 1'b0;
            ctrl.vtype_sel = !vec_inst[31];
            ctrl.rs1rd_de  = !rs1_rd_zero;
            ctrl.rs1_sel   = rs1_rd_zero;
          end
        end
      end
      V_LOAD, V_STORE: begin
        if (mem_width_ok(funct3)) begin
          legal              = 1'b1;
          is_mem             = 1'b1;
          ctrl.ld_inst       = (opcode == V_LOAD);
          ctrl.st_inst       = (opcode == V_STORE);
          ctrl.vec_reg_wr_en = (opcode == V_LOAD);
          ctrl.rs1_sel       = 1'b1;
          ctrl.rs1rd_de      = 1'b1;
          ctrl.lumop_sel     = 1'b1;
          ctrl.vtype_sel     = 1'b1;
          ctrl.data_mux1_sel = 2'b01;
          case (mop)
            MOP_UNIT: begin
              ctrl.stride_sel    = 1'b1;
              ctrl.data_mux2_sel = 1'b1;
            end
            MOP_STRIDED: begin
              ctrl.stride_sel    = 1'b0;
              ctrl.data_mux2_sel = 1'b1;
            end
            default: begin
              ctrl.index_str     = 1'b1;
              ctrl.data_mux2_sel = 1'b0;
              ordered            = (mop == MOP_IDX_ORD);
            end
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vector_seq_controller.sv
// Sequential vector instruction controller: accepts one instruction over a
// valid/ready port, holds its control word, and either strobes a CSR write
// or splits a load/store into LSU beats of up to LANES elements.
module vector_seq_controller
  import vec_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int VLEN  = 512,
  parameter int LANES = 4,
  parameter int VL_W  = $clog2(VLEN) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inst_valid,
  output logic                   inst_ready,
  input  logic [XLEN-1:0]        vec_inst,
  input  logic                   flush,
  input  logic [VL_W-1:0]        vl,
  output logic                   lsu_req_valid,
  input  logic                   lsu_req_ready,
  output logic [VL_W-1:0]        lsu_elem_idx,
  output logic [$clog2(LANES):0] lsu_elem_cnt,
  input  logic                   lsu_done,
  output logic                   csrwr_en,
  output logic                   vl_sel,
  output logic                   vtype_sel,
  output logic                   rs1_sel,
  output logic                   rs1rd_de,
  output logic                   lumop_sel,
  output logic                   vec_reg_wr_en,
  output logic [1:0]             data_mux1_sel,
  output logic                   data_mux2_sel,
  output logic                   stride_sel,
  output logic                   index_str,
  output logic                   ld_inst,
  output logic                   st_inst,
  output logic                   busy,
  output logic                   illegal_inst
);

  localparam int CNT_W = $clog2(LANES) + 1;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_CONF  = CONF;
  localparam logic [1:0] ST_MEM   = MEM;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  vec_ctrl_word_t   dec_ctrl;
  vec_ctrl_word_t   ctrl_q;
  logic             dec_legal;
  logic             dec_conf;
  logic             dec_mem;
  logic             dec_ordered;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [VL_W-1:0]  vl_q;
  logic [VL_W-1:0]  ptr;
  logic [VL_W-1:0]  ptr_next;
  logic [VL_W-1:0]  remaining;
  logic [VL_W-1:0]  vl_clamped;
  logic [CNT_W-1:0] beat_cnt;
  logic             ordered_q;
  logic             illegal_q;
  logic             accept;
  logic             beat_fire;

  vec_inst_decoder #(
    .XLEN (XLEN)
  ) u_decoder (
    .vec_inst (vec_inst),
    .ctrl     (dec_ctrl),
    .legal    (dec_legal),
    .is_conf  (dec_conf),
    .is_mem   (dec_mem),
    .ordered  (dec_ordered)
  );

  assign accept     = inst_valid && inst_ready;
  assign beat_fire  = lsu_req_valid && lsu_req_ready;
  assign vl_clamped = (vl > VL_W'(VLEN)) ? VL_W'(VLEN) : vl;
  // ptr never passes vl_q, so this cannot wrap
  assign remaining  = vl_q - ptr;
  assign ptr_next   = ptr + VL_W'(beat_cnt);

  // Beat size: one element for ordered indexed, otherwise min(LANES, remaining)
  always_comb begin
    beat_cnt = '0;
    if (state == ST_MEM) begin
      if (ordered_q) begin
        beat_cnt = CNT_W'(1);
      end else if (remaining >= VL_W'(LANES)) begin
        beat_cnt = CNT_W'(LANES);
      end else begin
        beat_cnt = remaining[CNT_W-1:0];
      end
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept && dec_legal) begin
          if (dec_conf)                state_nxt = ST_CONF;
          else if (vl_clamped == '0)   state_nxt = ST_DRAIN;
          else if (dec_mem)            state_nxt = ST_MEM;
        end
      end
      ST_CONF:  state_nxt = ST_IDLE;
      ST_MEM:   if (beat_fire && (ptr_next == vl_q)) state_nxt = ST_DRAIN;
      ST_DRAIN: if ((vl_q == '0) || lsu_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  // State, latched instruction context and beat pointer
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ctrl_q    <= '0;
      vl_q      <= '0;
      ptr       <= '0;
      ordered_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      illegal_q <= accept && !dec_legal && !flush;
      if (state_nxt == ST_IDLE) begin
        ctrl_q    <= '0;
        vl_q      <= '0;
        ptr       <= '0;
        ordered_q <= 1'b0;
      end else if (state == ST_IDLE) begin
        ctrl_q    <= dec_ctrl;
        vl_q      <= vl_clamped;
        ptr       <= '0;
        ordered_q <= dec_ordered;
      end else if (beat_fire) begin
        ptr <= ptr_next;
      end
    end
  end

  assign inst_ready    = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign csrwr_en      = (state == ST_CONF);
  assign lsu_req_valid = (state == ST_MEM);
  assign lsu_elem_idx  = (state == ST_MEM) ? ptr : '0;
  assign lsu_elem_cnt  = beat_cnt;
  assign illegal_inst  = illegal_q;

  assign vl_sel        = ctrl_q.vl_sel;
  assign vtype_sel     = ctrl_q.vtype_sel;
  assign rs1_sel       = ctrl_q.rs1_sel;
  assign rs1rd_de      = ctrl_q.rs1rd_de;
  assign lumop_sel     = ctrl_q.lumop_sel;
  assign vec_reg_wr_en = ctrl_q.vec_reg_wr_en;
  assign data_mux1_sel = ctrl_q.data_mux1_sel;
  assign data_mux2_sel = ctrl_q.data_mux2_sel;
  assign stride_sel    = ctrl_q.stride_sel;
  assign index_str     = ctrl_q.index_str;
  assign ld_inst       = ctrl_q.ld_inst;
  assign st_inst       = ctrl_q.st_inst;

endmodule

// File: tb/tb_vector_seq_controller.sv
// Scoreboard bench for vector_seq_controller: stimulus pushes expected
// CSR strobes, LSU beats and illegal pulses; a negedge monitor pops and
// compares each one as the DUT presents it.
module tb_vector_seq_controller;

  localparam int XLEN  = 32;
  localparam int VLEN  = 512;
  localparam int LANES = 4;
  localparam int VL_W  = $clog2(VLEN) + 1;
  localparam int CNT_W = $clog2(LANES) + 1;

  localparam int K_NONE = 0;
  localparam int K_CSR  = 1;
  localparam int K_BEAT = 2;
  localparam int K_ILL  = 3;

  // {vl_sel,vtype_sel,rs1_sel,rs1rd_de,lumop_sel,wr_en,mux1[1:0],mux2,stride,index,ld,st}
  localparam logic [12:0] C_VSETVLI_RS = 13'b0_1_0_1_0_0_00_0_0_0_0_0;
  localparam logic [12:0] C_VSETVLI_Z  = 13'b0_1_1_0_0_0_00_0_0_0_0_0;
  localparam logic [12:0] C_VSETIVLI   = 13'b1_1_0_1_0_0_00_0_0_0_0_0;
  localparam logic [12:0] C_VSETVL_Z   = 13'b0_0_1_0_0_0_00_0_0_0_0_0;
  localparam logic [12:0] C_LD_UNIT    = 13'b0_1_1_1_1_1_01_1_1_0_1_0;
  localparam logic [12:0] C_LD_STRIDE  = 13'b0_1_1_1_1_1_01_1_0_0_1_0;
  localparam logic [12:0] C_ST_IDXORD  = 13'b0_1_1_1_1_0_01_0_0_1_0_1;

  localparam logic [31:0] I_VSETVLI_RS = 32'h0C0372D7; // vsetvli x5,x6
  localparam logic [31:0] I_VSETVLI_Z  = 32'h0C007057; // rs1=rd=x0
  localparam logic [31:0] I_VSETIVLI   = 32'hC0007057;
  localparam logic [31:0] I_VSETVL_Z   = 32'h80007057;
  localparam logic [31:0] I_LD_UNIT    = 32'h02016087; // mop 00, width 110
  localparam logic [31:0] I_LD_STRIDE  = 32'h0A016087; // mop 10
  localparam logic [31:0] I_ST_IDXORD  = 32'h0E0170A7; // mop 11, width 111
  localparam logic [31:0] I_OP_ALU     = 32'h00000033; // opcode 0110011
  localparam logic [31:0] I_LD_BADW    = 32'h02011087; // width 001

  typedef struct {
    int          kind;
    int          idx;
    int          cnt;
    logic [12:0] ctrl;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             inst_valid;
  logic             inst_ready;
  logic [XLEN-1:0]  vec_inst;
  logic             flush;
  logic [VL_W-1:0]  vl;
  logic             lsu_req_valid;
  logic             lsu_req_ready;
  logic [VL_W-1:0]  lsu_elem_idx;
  logic [CNT_W-1:0] lsu_elem_cnt;
  logic             lsu_done;
  logic             csrwr_en;
  logic             vl_sel, vtype_sel, rs1_sel, rs1rd_de, lumop_sel;
  logic             vec_reg_wr_en;
  logic [1:0]       data_mux1_sel;
  logic             data_mux2_sel;
  logic             stride_sel, index_str, ld_inst, st_inst;
  logic             busy;
  logic             illegal_inst;

  logic [12:0]      ctrl_out;
  exp_t             sb[$];
  int               n_checks = 0;
  int               n_pass   = 0;

  logic             stalled;
  logic [VL_W-1:0]  stall_idx;
  logic [CNT_W-1:0] stall_cnt;

  assign ctrl_out = {vl_sel, vtype_sel, rs1_sel, rs1rd_de, lumop_sel, vec_reg_wr_en,
                     data_mux1_sel, data_mux2_sel, stride_sel, index_str, ld_inst, st_inst};

  vector_seq_controller #(
    .XLEN (XLEN), .VLEN (VLEN), .LANES (LANES), .VL_W (VL_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .vec_inst      (vec_inst),
    .flush         (flush),
    .vl            (vl),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_elem_idx  (lsu_elem_idx),
    .lsu_elem_cnt  (lsu_elem_cnt),
    .lsu_done      (lsu_done),
    .csrwr_en      (csrwr_en),
    .vl_sel        (vl_sel),
    .vtype_sel     (vtype_sel),
    .rs1_sel       (rs1_sel),
    .rs1rd_de      (rs1rd_de),
    .lumop_sel     (lumop_sel),
    .vec_reg_wr_en (vec_reg_wr_en),
    .data_mux1_sel (data_mux1_sel),
    .data_mux2_sel (data_mux2_sel),
    .stride_sel    (stride_sel),
    .index_str     (index_str),
    .ld_inst       (ld_inst),
    .st_inst       (st_inst),
    .busy          (busy),
    .illegal_inst  (illegal_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int idx, input int cnt, input logic [12:0] ctrl);
    exp_t e;
    e.kind = kind; e.idx = idx; e.cnt = cnt; e.ctrl = ctrl;
    sb.push_back(e);
  endtask

  // Present one instruction for exactly one accepting edge
  task automatic send(input logic [31:0] inst, input int v);
    int n = 0;
    while (!inst_ready && n < 50) begin tick(); n++; end
    check("send_ready", inst_ready, 1);
    vec_inst   = inst;
    vl         = VL_W'(v);
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
  endtask

  // Serve LSU beats until the request line drops; toggle=1 stalls every other cycle
  task automatic finish_mem(input bit toggle, input int budget);
    int n = 0;
    while (lsu_req_valid && n < budget) begin
      lsu_req_ready = toggle ? n[0] : 1'b1;
      tick();
      n++;
    end
    lsu_req_ready = 1'b0;
    check("mem_phase_done", lsu_req_valid, 0);
  endtask

  // DRAIN must hold until lsu_done, then return to IDLE
  task automatic drain();
    check("drain_busy", busy, 1);
    tick();
    tick();
    check("drain_holds_without_done", busy, 1);
    lsu_done = 1'b1;
    tick();
    lsu_done = 1'b0;
    check("drain_exit_ready", inst_ready, 1);
  endtask

  task automatic check_idle(input string name);
    check({name, "_ctrl"}, ctrl_out, 0);
    check({name, "_misc"}, {csrwr_en, lsu_req_valid, busy, illegal_inst,
                            lsu_elem_idx, lsu_elem_cnt}, 0);
    check({name, "_ready"}, inst_ready, 1);
  endtask

  task automatic run_conf(input logic [31:0] inst, input logic [12:0] ctrl);
    push(K_CSR, 0, 0, ctrl);
    send(inst, 7);
    tick();
    check("csrwr_one_cycle", csrwr_en, 0);
    check("conf_back_ready", inst_ready, 1);
  endtask

  // Monitor: pop and compare every DUT-presented event
  always @(negedge clk) begin
    exp_t e;
    int   kind;
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (csrwr_en || (lsu_req_valid && lsu_req_ready) || illegal_inst) begin
        kind = csrwr_en ? K_CSR : (illegal_inst ? K_ILL : K_BEAT);
        if (sb.size() != 0) e = sb.pop_front();
        else begin e.kind = K_NONE; e.idx = 0; e.cnt = 0; e.ctrl = '0; end
        check("event_kind", kind, e.kind);
        if (kind == K_BEAT) begin
          check("beat_idx", lsu_elem_idx, e.idx);
          check("beat_cnt", lsu_elem_cnt, e.cnt);
        end
        if (kind == K_ILL) begin
          check("illegal_ctrl", ctrl_out, 0);
          check("illegal_not_busy", busy, 0);
        end else begin
          check("event_ctrl", ctrl_out, e.ctrl);
        end
      end
      if (stalled && lsu_req_valid) begin
        check("stall_idx_stable", lsu_elem_idx, stall_idx);
        check("stall_cnt_stable", lsu_elem_cnt, stall_cnt);
      end
      stalled   = lsu_req_valid && !lsu_req_ready;
      stall_idx = lsu_elem_idx;
      stall_cnt = lsu_elem_cnt;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stalled       = 1'b0;
    reset         = 1'b1;
    inst_valid    = 1'b0;
    vec_inst      = '0;
    flush         = 1'b0;
    vl            = '0;
    lsu_req_ready = 1'b0;
    lsu_done      = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_idle("reset");

    // Config instructions
    run_conf(I_VSETVLI_RS, C_VSETVLI_RS);
    run_conf(I_VSETVLI_Z,  C_VSETVLI_Z);
    run_conf(I_VSETIVLI,   C_VSETIVLI);
    run_conf(I_VSETVL_Z,   C_VSETVL_Z);

    // Unit-stride load, vl=10: (0,4),(4,4),(8,2)
    push(K_BEAT, 0, 4, C_LD_UNIT);
    push(K_BEAT, 4, 4, C_LD_UNIT);
    push(K_BEAT, 8, 2, C_LD_UNIT);
    send(I_LD_UNIT, 10);
    check("first_beat_next_cycle", lsu_req_valid, 1);
    finish_mem(1'b0, 20);
    drain();

    // Strided load, vl=5: (0,4),(4,1)
    push(K_BEAT, 0, 4, C_LD_STRIDE);
    push(K_BEAT, 4, 1, C_LD_STRIDE);
    send(I_LD_STRIDE, 5);
    finish_mem(1'b0, 20);
    drain();

    // Ordered indexed store, vl=3, stalling ready: (0,1),(1,1),(2,1)
    for (int i = 0; i < 3; i++) push(K_BEAT, i, 1, C_ST_IDXORD);
    send(I_ST_IDXORD, 3);
    finish_mem(1'b1, 20);
    drain();

    // vl above VLEN is clamped to 512 elements: 128 full beats
    for (int i = 0; i < VLEN / LANES; i++) push(K_BEAT, i * LANES, LANES, C_LD_UNIT);
    send(I_LD_UNIT, 600);
    finish_mem(1'b0, 400);
    drain();

    // vl=0: no beats, back to IDLE two cycles after accept
    send(I_LD_UNIT, 0);
    check("vl0_busy", busy, 1);
    check("vl0_no_req", lsu_req_valid, 0);
    tick();
    check("vl0_idle", inst_ready, 1);

    // Illegal instructions: single pulse, never busy
    push(K_ILL, 0, 0, '0);
    send(I_OP_ALU, 4);
    check("illegal_pulse", illegal_inst, 1);
    tick();
    check("illegal_single", illegal_inst, 0);
    push(K_ILL, 0, 0, '0);
    send(I_LD_BADW, 4);
    tick();
    check("illegal_single_w", illegal_inst, 0);
    check("illegal_idle", busy, 0);

    // Flush after two beats of a 16-element load
    push(K_BEAT, 0, 4, C_LD_UNIT);
    push(K_BEAT, 4, 4, C_LD_UNIT);
    send(I_LD_UNIT, 16);
    lsu_req_ready = 1'b1;
    tick();
    tick();
    lsu_req_ready = 1'b0;
    flush         = 1'b1;
    tick();
    flush = 1'b0;
    check_idle("flush");
    tick();
    check("flush_no_more_req", lsu_req_valid, 0);

    // Reset in DRAIN
    push(K_BEAT, 0, 4, C_LD_UNIT);
    send(I_LD_UNIT, 4);
    finish_mem(1'b0, 20);
    check("pre_reset_drain", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("reset_drain");
    tick();
    check("reset_stays_idle", busy, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
